// File: rtl/rfile_mp.sv
// Multi-ported integer register file: byte-lane sub-word writes with per-byte port priority,
// registered reads that see this cycle's merged writes, optional hardwired zero register.
module rfile_mp #(
    parameter int XLEN     = 64,
    parameter int XN       = 64,
    parameter int XWDT     = 6,
    parameter int NREAD    = 3,
    parameter int NWRITE   = 2,
    parameter int SZW      = 2,
    parameter int POSW     = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREAD-1:0]               res,
    input  logic [NREAD-1:0][XWDT-1:0]     rreads,
    output logic [NREAD-1:0][XLEN-1:0]     routs,
    output logic [NREAD-1:0]               rvalids,
    input  logic [NWRITE-1:0]              wes,
    input  logic [NWRITE-1:0][XWDT-1:0]    rwrites,
    input  logic [NWRITE-1:0][XLEN-1:0]    rins,
    input  logic [NWRITE-1:0][SZW-1:0]     rwsizes,
    input  logic [NWRITE-1:0][POSW-1:0]    rwposs
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0]               regs      [XN];
    logic [XLEN-1:0]               next_regs [XN];
    logic [NWRITE-1:0]             wen;
    logic [NWRITE-1:0][NB-1:0]     wmask;
    logic [NWRITE-1:0][XLEN-1:0]   wdata;
    logic [NREAD-1:0][XLEN-1:0]    rd_data;

    function automatic int lane_bytes(input logic [SZW-1:0] s);
        return 1 << s;
    endfunction

    // Out-of-range lanes leave the mask empty, which drops the whole write.
    always_comb begin
        wen   = '0;
        wmask = '0;
        wdata = '0;
        for (int i = 0; i < NWRITE; i++) begin
            wen[i] = wes[i] && (int'(rwrites[i]) < XN)
                     && !(ZERO_REG != 0 && rwrites[i] == '0);
            if (lane_bytes(rwsizes[i]) >= NB) begin
                wmask[i] = '1;
                wdata[i] = rins[i];
            end else if ((int'(rwposs[i]) + 1) * lane_bytes(rwsizes[i]) <= NB) begin
                for (int b = 0; b < NB; b++) begin
                    if (b >= int'(rwposs[i]) * lane_bytes(rwsizes[i]) &&
                        b < (int'(rwposs[i]) + 1) * lane_bytes(rwsizes[i])) begin
                        wmask[i][b]        = 1'b1;
                        wdata[i][b*8 +: 8] = rins[i][(b - int'(rwposs[i]) * lane_bytes(rwsizes[i]))*8 +: 8];
                    end
                end
            end
        end
    end

    // Ports are scanned in ascending order so the highest-numbered port owns each byte.
    always_comb begin
        for (int r = 0; r < XN; r++) begin
            next_regs[r] = regs[r];
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < NWRITE; i++) begin
                    if (wen[i] && int'(rwrites[i]) == r && wmask[i][b]) begin
                        next_regs[r][b*8 +: 8] = wdata[i][b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < NREAD; j++) begin
            if (int'(rreads[j]) < XN && !(ZERO_REG != 0 && rreads[j] == '0)) begin
                rd_data[j] = next_regs[rreads[j]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < XN; r++) begin
                regs[r] <= '0;
            end
            routs   <= '0;
            rvalids <= '0;
        end else begin
            for (int r = 0; r < XN; r++) begin
                regs[r] <= next_regs[r];
            end
            rvalids <= res;
            for (int j = 0; j < NREAD; j++) begin
                if (res[j]) begin
                    routs[j] <= rd_data[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_rfile_mp.sv
// Scoreboard bench for rfile_mp: directed scenarios then random traffic, checked against
// a value-level register model with per-port held outputs.
module tb_rfile_mp;

    localparam int XLEN   = 64;
    localparam int XN     = 48;
    localparam int XWDT   = 6;
    localparam int NREAD  = 3;
    localparam int NWRITE = 2;
    localparam int SZW    = 2;
    localparam int POSW   = 3;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NREAD-1:0]              res;
    logic [NREAD-1:0][XWDT-1:0]    rreads;
    logic [NREAD-1:0][XLEN-1:0]    routs;
    logic [NREAD-1:0]              rvalids;
    logic [NWRITE-1:0]             wes;
    logic [NWRITE-1:0][XWDT-1:0]   rwrites;
    logic [NWRITE-1:0][XLEN-1:0]   rins;
    logic [NWRITE-1:0][SZW-1:0]    rwsizes;
    logic [NWRITE-1:0][POSW-1:0]   rwposs;

    rfile_mp #(
        .XLEN(XLEN), .XN(XN), .XWDT(XWDT), .NREAD(NREAD), .NWRITE(NWRITE),
        .SZW(SZW), .POSW(POSW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .res(res), .rreads(rreads), .routs(routs),
        .rvalids(rvalids), .wes(wes), .rwrites(rwrites), .rins(rins),
        .rwsizes(rwsizes), .rwposs(rwposs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREAD-1:0]            rv;
        logic [NREAD-1:0][XLEN-1:0]  outs;
    } exp_t;

    exp_t            exp_q [$];
    logic [XLEN-1:0] m_regs [64];
    logic [XLEN-1:0] m_out  [NREAD];
    int              checks = 0;
    int              passes = 0;
    bit              mon_en = 1'b0;

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clearOps();
        res = '0; rreads = '0; wes = '0; rwrites = '0; rins = '0; rwsizes = '0; rwposs = '0;
    endtask

    task automatic setWrite(input int port, input int idx, input logic [XLEN-1:0] data, input int s, input int p);
        wes[port]     = 1'b1;
        rwrites[port] = XWDT'(idx);
        rins[port]    = data;
        rwsizes[port] = SZW'(s);
        rwposs[port]  = POSW'(p);
    endtask

    task automatic setRead(input int port, input int idx);
        res[port]    = 1'b1;
        rreads[port] = XWDT'(idx);
    endtask

    task automatic clearModel();
        for (int r = 0; r < 64; r++) m_regs[r] = '0;
        for (int j = 0; j < NREAD; j++) m_out[j] = '0;
    endtask

    // Writes land in port order so later ports overwrite earlier ones; reads see the result.
    task automatic modelCycle();
        exp_t e;
        for (int i = 0; i < NWRITE; i++) begin
            int w;
            int p;
            int idx;
            logic [XLEN-1:0] mask;
            w   = 8 << rwsizes[i];
            p   = int'(rwposs[i]);
            idx = int'(rwrites[i]);
            if (wes[i] && idx < XN && idx != 0) begin
                if (w >= XLEN) begin
                    m_regs[idx] = rins[i];
                end else if ((p + 1) * w <= XLEN) begin
                    mask = ((64'd1 << w) - 64'd1) << (p * w);
                    m_regs[idx] = (m_regs[idx] & ~mask) | ((rins[i] << (p * w)) & mask);
                end
            end
        end
        e.rv = res;
        for (int j = 0; j < NREAD; j++) begin
            if (res[j]) begin
                m_out[j] = (int'(rreads[j]) < XN && rreads[j] != '0) ? m_regs[rreads[j]] : '0;
            end
            e.outs[j] = m_out[j];
        end
        exp_q.push_back(e);
    endtask

    // Inputs are already set by the caller; an optional reset pulse sits between clock edges.
    task automatic applyStimulus(input bit do_reset);
        if (do_reset) begin
            #1 rst_n = 1'b0;
            #1;
            checkOutput("rvalids_in_reset", XLEN'(rvalids), '0);
            for (int j = 0; j < NREAD; j++) checkOutput($sformatf("routs%0d_in_reset", j), routs[j], '0);
            clearModel();
            #1 rst_n = 1'b1;
        end
        modelCycle();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL scoreboard_empty: got no expectation expected one per cycle");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rvalids", XLEN'(rvalids), XLEN'(e.rv));
                for (int j = 0; j < NREAD; j++) checkOutput($sformatf("routs%0d", j), routs[j], e.outs[j]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clearOps();
        clearModel();
        setWrite(0, 5, 64'h0123_4567_89AB_CDEF, 3, 0);
        res = '1;
        repeat (2) @(negedge clk);
        checkOutput("rvalids_init_reset", XLEN'(rvalids), '0);
        checkOutput("routs0_init_reset", routs[0], '0);
        #1 clearOps();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Reset clears a written register.
        setWrite(0, 5, 64'hDEADBEEF_CAFEF00D, 3, 0); applyStimulus(0); clearOps();
        setRead(0, 5); applyStimulus(1); clearOps();
        applyStimulus(0);

        // Sub-word lanes on x7, including a dropped out-of-range half.
        setWrite(0, 7, 64'h0, 3, 0);               applyStimulus(0); clearOps();
        setWrite(1, 7, 64'hFFFF_FFFF_FFFF_FFAB, 0, 3); applyStimulus(0); clearOps();
        setWrite(0, 7, 64'h1234, 1, 2);            applyStimulus(0); clearOps();
        setWrite(1, 7, 64'h55667788, 2, 0);        applyStimulus(0); clearOps();
        setRead(1, 7);                             applyStimulus(0); clearOps();
        setWrite(0, 7, 64'h9999, 1, 4); setRead(2, 7); applyStimulus(0); clearOps();

        // Port priority in both orders.
        setWrite(0, 9, 64'h11111111_11111111, 3, 0); setWrite(1, 9, 64'hBEEF, 1, 0);
        setRead(0, 9); applyStimulus(0); clearOps();
        setWrite(0, 9, 64'hBEEF, 1, 0); setWrite(1, 9, 64'h11111111_11111111, 3, 0);
        setRead(1, 9); applyStimulus(0); clearOps();

        // Bypass then hold.
        setWrite(0, 3, 64'h42, 3, 0); setRead(0, 3); setRead(2, 3); applyStimulus(0); clearOps();
        setRead(1, 3); applyStimulus(0); clearOps();
        setWrite(1, 3, 64'h99, 3, 0); applyStimulus(0); clearOps();

        // Zero register and out-of-range index.
        setWrite(0, 0, 64'hFF, 0, 0); setRead(0, 0); applyStimulus(0); clearOps();
        setWrite(1, 50, 64'hA5A5_A5A5_A5A5_A5A5, 3, 0); setRead(0, 50); setRead(1, 3); setRead(2, 9);
        applyStimulus(0); clearOps();
        setRead(0, 7); setRead(1, 47); setRead(2, 2); applyStimulus(0); clearOps();

        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NWRITE; i++) begin
                if ($urandom_range(0, 3) != 0)
                    setWrite(i, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 11)),
                             {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            end
            for (int j = 0; j < NREAD; j++) begin
                if ($urandom_range(0, 2) != 0)
                    setRead(j, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 11)));
            end
            applyStimulus($urandom_range(0, 63) == 0);
            clearOps();
        end

        mon_en = 1'b0;
        #2;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
